// File: rtl/fc_pkg.sv
// fc_pkg: shared types, constants and saturation helper for the FC layers
package fc_pkg;
   localparam int DATA_W = 16;
   localparam int FRAC_W = 8;
   localparam int N_OUT  = 10;
   localparam int ACC_W  = 40;
   typedef logic signed [DATA_W-1:0] data_t;
   typedef logic signed [ACC_W-1:0]  acc_t;
   typedef enum logic [2:0] {S_IDLE, S_BIAS, S_MAC, S_WRITE, S_DONE} fc_state_e;
   localparam acc_t SAT_MAX = (acc_t'(1) <<< (DATA_W-1)) - acc_t'(1);
   localparam acc_t SAT_MIN = -(acc_t'(1) <<< (DATA_W-1));
   // drop fractional product bits (floor) and clamp into the data range
   function automatic data_t sat_round(input acc_t a);
      acc_t s;
      s = a >>> FRAC_W;
      return (s > SAT_MAX) ? data_t'(SAT_MAX) : (s < SAT_MIN) ? data_t'(SAT_MIN) : data_t'(s);
   endfunction
endpackage

// File: rtl/fc_output_layer_mac.sv
// fc_mac: registered multiply-accumulate with bias preload and saturating output
module fc_mac
   import fc_pkg::*;
(
   input  logic  clk,
   input  logic  rst,
   input  logic  i_en,
   input  logic  i_load,
   input  data_t i_bias,
   input  data_t i_a,
   input  data_t i_b,
   output data_t o_sat
);
   acc_t r_acc;
   acc_t w_base;
   assign w_base = i_load ? (acc_t'(i_bias) <<< FRAC_W) : r_acc;
   // first term restarts from the scaled bias, later terms add onto the running sum
   always_ff @(posedge clk or posedge rst)
      if (rst) r_acc <= '0;
      else if (i_en) r_acc <= w_base + acc_t'(i_a) * acc_t'(i_b);
   assign o_sat = sat_round(r_acc);
endmodule

// File: rtl/fc_output_layer.sv
// fc_output_layer: sequential bias + dot-product output layer feeding the argmax stage
module fc_output_layer
   import fc_pkg::*;
#(
   parameter  int N_IN = 64,
   localparam int IA_W = (N_IN > 1) ? $clog2(N_IN) : 1,
   localparam int WA_W = (N_IN * N_OUT > 1) ? $clog2(N_IN * N_OUT) : 1,
   localparam int BA_W = (N_OUT > 1) ? $clog2(N_OUT) : 1,
   localparam int CW   = $clog2(N_IN + 1)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_start,
   output logic            o_busy,
   output logic [IA_W-1:0] o_in_addr,
   input  data_t           i_in_data,
   output logic [WA_W-1:0] o_w_addr,
   input  data_t           i_w_data,
   output logic [BA_W-1:0] o_b_addr,
   input  data_t           i_b_data,
   output data_t           o_outing [N_OUT],
   output logic            o_max_signal
);
   fc_state_e       r_state, w_next;
   logic [BA_W-1:0] r_j;
   logic [CW-1:0]   r_c;
   data_t           r_res [N_OUT];
   data_t           r_out [N_OUT];
   data_t           w_sat;
   logic            w_last_k, w_last_j;
   assign w_last_k  = r_c == CW'(N_IN);
   assign w_last_j  = r_j == BA_W'(N_OUT - 1);
   assign o_in_addr = IA_W'(r_c);
   assign o_b_addr  = r_j;
   assign o_w_addr  = WA_W'(int'(r_j) * N_IN + int'(r_c));
   assign o_outing  = r_out;
   // next-state and status outputs
   always_comb begin
      w_next       = r_state;
      o_busy       = 1'b0;
      o_max_signal = 1'b0;
      case (r_state)
         S_IDLE:  w_next = i_start ? S_BIAS : S_IDLE;
         S_BIAS:  begin w_next = S_MAC; o_busy = 1'b1; end
         S_MAC:   begin w_next = w_last_k ? S_WRITE : S_MAC; o_busy = 1'b1; end
         S_WRITE: begin w_next = w_last_j ? S_DONE : S_BIAS; o_busy = 1'b1; end
         S_DONE:  begin w_next = S_IDLE; o_max_signal = 1'b1; end
         default: w_next = S_IDLE;
      endcase
   end
   // state register
   always_ff @(posedge clk or posedge rst)
      if (rst) r_state <= S_IDLE;
      else r_state <= w_next;
   // neuron index j and MAC cycle counter c (c doubles as the activation address)
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_j <= '0;
         r_c <= '0;
      end else case (r_state)
         S_BIAS:  r_c <= CW'(1);
         S_MAC:   r_c <= w_last_k ? r_c : r_c + CW'(1);
         S_WRITE: begin
            r_c <= '0;
            r_j <= w_last_j ? r_j : r_j + BA_W'(1);
         end
         default: begin
            r_j <= '0;
            r_c <= '0;
         end
      endcase
   fc_mac u_mac (
      .clk    (clk),
      .rst    (rst),
      .i_en   (r_state == S_MAC),
      .i_load (r_c == CW'(1)),
      .i_bias (i_b_data),
      .i_a    (i_in_data),
      .i_b    (i_w_data),
      .o_sat  (w_sat)
   );
   // bank each neuron result; publish the whole bank together as the last neuron lands,
   // so outing changes exactly when max_signal is raised and never shows a partial run
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_res <= '{default: '0};
         r_out <= '{default: '0};
      end else if (r_state == S_WRITE) begin
         r_res[r_j] <= w_sat;
         if (w_last_j)
            for (int i = 0; i < N_OUT; i++) r_out[i] <= (i == N_OUT - 1) ? w_sat : r_res[i];
      end
endmodule

// File: tb/tb_fc_output_layer.sv
// tb_fc_output_layer: randomized scoreboard bench for fc_output_layer with N_IN=4
module tb_fc_output_layer;
   import fc_pkg::*;
   localparam int NI = 4;
   localparam int NO = N_OUT;
   typedef struct packed {
      logic [NO-1:0][15:0] v;
      int                  at;
   } exp_t;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic       busy, max_signal;
   logic [1:0] in_addr;
   logic [5:0] w_addr;
   logic [3:0] b_addr;
   data_t      in_data, w_data, b_data;
   data_t      outing [NO];
   data_t      act [NI];
   data_t      wt [NI*NO];
   data_t      bs [NO];
   exp_t       q [$];
   exp_t       e, last;
   int         cyc = 0;
   int         checks = 0, errors = 0, n_done = 0;

   fc_output_layer #(.N_IN(NI)) dut (
      .clk          (clk),
      .rst          (rst),
      .i_start      (start),
      .o_busy       (busy),
      .o_in_addr    (in_addr),
      .i_in_data    (in_data),
      .o_w_addr     (w_addr),
      .i_w_data     (w_data),
      .o_b_addr     (b_addr),
      .i_b_data     (b_data),
      .o_outing     (outing),
      .o_max_signal (max_signal)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // synchronous memories, one cycle read latency
   always @(posedge clk) begin
      in_data <= act[in_addr];
      w_data  <= (int'(w_addr) < NI*NO) ? wt[w_addr] : '0;
      b_data  <= (int'(b_addr) < NO) ? bs[b_addr] : '0;
   end

   task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, want);
      end
   endtask

   // reference: out[j] = clamp(floor((bias*256 + sum a*w) / 256))
   function automatic exp_t model(input int at);
      exp_t r;
      for (int j = 0; j < NO; j++) begin
         longint acc, fl;
         acc = longint'(bs[j]) * 256;
         for (int k = 0; k < NI; k++) acc += longint'(act[k]) * longint'(wt[j*NI+k]);
         fl = (acc >= 0) ? acc / 256 : -((-acc + 255) / 256);
         if (fl > 32767) fl = 32767;
         if (fl < -32768) fl = -32768;
         r.v[j] = fl[15:0];
      end
      r.at = at;
      return r;
   endfunction

   // monitor: every max_signal pops one expectation and checks timing and all outputs
   always @(negedge clk) if (!rst && max_signal) begin
      if (q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL unexpected_pulse: got max_signal at cycle %0d expected none", cyc);
      end else begin
         e = q.pop_front();
         checks++;
         if (cyc != e.at) begin
            errors++;
            $display("FAIL pulse_cycle: got %0d expected %0d", cyc, e.at);
         end
         for (int j = 0; j < NO; j++) chk($sformatf("outing[%0d]", j), outing[j], e.v[j]);
         last = e;
      end
      n_done++;
   end

   task automatic launch(output int p);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      p = cyc;
      start = 1'b0;
   endtask

   task automatic wait_done(input int prev, input int budget);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         #2;
         if (n_done > prev) break;
      end
      checks++;
      if (n_done <= prev) begin
         errors++;
         $display("FAIL timeout: got %0d pulses expected more than %0d", n_done, prev);
      end
   endtask

   task automatic fill_random(input bit full);
      for (int k = 0; k < NI; k++) act[k] = full ? data_t'($urandom) : data_t'($urandom_range(0, 2047)) - 16'sd1024;
      for (int i = 0; i < NI*NO; i++) wt[i] = full ? data_t'($urandom) : data_t'($urandom_range(0, 2047)) - 16'sd1024;
      for (int j = 0; j < NO; j++) bs[j] = data_t'($urandom_range(0, 4095)) - 16'sd2048;
   endtask

   task automatic run_checked();
      int p, n0;
      n0 = n_done;
      launch(p);
      q.push_back(model(p + 60));
      wait_done(n0, 100);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int p, n0;
      for (int k = 0; k < NI; k++) act[k] = '0;
      for (int i = 0; i < NI*NO; i++) wt[i] = '0;
      for (int j = 0; j < NO; j++) bs[j] = '0;
      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_busy", busy, 0);
      chk("reset_max", max_signal, 0);
      chk("reset_in_addr", in_addr, 0);
      chk("reset_w_addr", w_addr, 0);
      chk("reset_b_addr", b_addr, 0);
      for (int j = 0; j < NO; j++) chk($sformatf("reset_outing[%0d]", j), outing[j], 0);
      rst = 1'b0;

      // basic dot product with exact busy window
      for (int k = 0; k < NI; k++) act[k] = 16'sh0100;
      for (int j = 0; j < NO; j++) for (int k = 0; k < NI; k++) wt[j*NI+k] = data_t'(16'h0100 * j);
      n0 = n_done;
      launch(p);
      q.push_back(model(p + 60));
      for (int c = 1; c <= 61; c++) begin
         @(negedge clk);
         chk($sformatf("busy_c%0d", c), busy, (c <= 60) ? 16'd1 : 16'd0);
      end
      wait_done(n0, 10);
      chk("basic_outing9", outing[9], 16'h2400);

      // reset in the middle of a run clears everything immediately
      n0 = n_done;
      launch(p);
      for (int c = 1; c < 20; c++) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_max", max_signal, 0);
      for (int j = 0; j < NO; j++) chk($sformatf("midrst_outing[%0d]", j), outing[j], 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (80) @(negedge clk);
      chk("midrst_no_pulse", 16'(n_done), 16'(n0));
      chk("midrst_idle_busy", busy, 0);

      // saturation high and low
      fill_random(1'b0);
      for (int k = 0; k < NI; k++) begin
         act[k] = 16'sh7FFF;
         wt[k] = 16'sh7FFF;
         wt[NI+k] = 16'sh8000;
      end
      run_checked();
      chk("sat_hi", outing[0], 16'h7FFF);
      chk("sat_lo", outing[1], 16'h8000);

      // bias only, then floor of a small negative
      for (int i = 0; i < NI*NO; i++) wt[i] = '0;
      for (int j = 0; j < NO; j++) bs[j] = data_t'(j);
      run_checked();
      chk("bias_outing7", outing[7], 16'd7);
      for (int k = 0; k < NI; k++) act[k] = 16'shFFFF;
      for (int i = 0; i < NI*NO; i++) wt[i] = 16'sh0001;
      for (int j = 0; j < NO; j++) bs[j] = '0;
      run_checked();
      chk("floor_outing3", outing[3], 16'hFFFF);

      // start pulse mid-run is ignored; outing holds the previous run until the pulse
      fill_random(1'b0);
      n0 = n_done;
      launch(p);
      q.push_back(model(p + 60));
      for (int c = 1; c <= 60; c++) begin
         @(negedge clk);
         if (c == 30) start = 1'b1;
         if (c == 31) start = 1'b0;
         if (c == 60) for (int j = 0; j < NO; j++) chk($sformatf("hold_outing[%0d]", j), outing[j], last.v[j]);
      end
      wait_done(n0, 10);
      repeat (70) @(negedge clk);
      chk("ignored_start_pulses", 16'(n_done), 16'(n0 + 1));

      // start held high: back-to-back runs with weights changed between them
      fill_random(1'b0);
      n0 = n_done;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      p = cyc;
      q.push_back(model(p + 60));
      wait_done(n0, 100);
      fill_random(1'b0);
      q.push_back(model(p + 122));
      @(posedge clk);
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(n0 + 1, 100);

      // random runs, full range and moderate range
      for (int r = 0; r < 4; r++) begin
         fill_random(r[0]);
         run_checked();
      end

      repeat (5) @(negedge clk);
      chk("scoreboard_empty", 16'(q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
